// File: rtl/cpu_defs.sv
// Shared CPU constants and types for the fetch path and the instruction memory.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package cpu_defs;

   localparam logic [31:0] CPU_RESET_PC   = 32'h0000_3000;
   localparam logic [31:0] CPU_EXC_VECTOR = 32'h0000_4180;
   localparam logic [31:0] CPU_NOP_WORD   = 32'h0000_0000;

   // Instruction memory window, inclusive word addresses.
   localparam logic [31:0] IM_ADDR_LO = 32'h0000_3000;
   localparam logic [31:0] IM_ADDR_HI = 32'h0000_6ffc;

   // Which source the next-PC mux picked; the IF/ID update keys off the same choice.
   typedef enum logic [2:0] {
      NPC_SEQ   = 3'd0,
      NPC_REDIR = 3'd1,
      NPC_HOLD  = 3'd2,
      NPC_ERET  = 3'd3,
      NPC_EXC   = 3'd4
   } npc_sel_t;

   // IF/ID pipeline register contents.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        valid;
      logic        adel;
      logic        bd;
   } ifid_t;

   // True when a fetch address is word aligned and inside the memory window.
   function automatic logic im_addr_ok(input logic [31:0] addr);
      return (addr[1:0] == 2'b00) && (addr >= IM_ADDR_LO) && (addr <= IM_ADDR_HI);
   endfunction

endpackage

// File: rtl/fetch_npc.sv
// Next-PC priority mux: exception > eret > stall (hold) > redirect > pc+4.
// Latency: purely combinational.
// Backpressure: stall holds the PC unless a flush (exc/eret) overrides it.
// Ports: pc/epc/redirect_pc in, control requests in, npc and the chosen source (sel) out.
module fetch_npc
   import cpu_defs::*;
#(
   parameter logic [31:0] EXC_VECTOR = CPU_EXC_VECTOR
) (
   input  logic [31:0] pc,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        exc_req,
   input  logic        eret_req,
   input  logic [31:0] epc,
   output logic [31:0] npc,
   output npc_sel_t    sel
);

   always_comb begin
      sel = NPC_SEQ;
      npc = pc + 32'd4;   // wraps modulo 2^32
      if (exc_req) begin
         sel = NPC_EXC;
         npc = EXC_VECTOR;
      end else if (eret_req) begin
         sel = NPC_ERET;
         npc = epc;
      end else if (stall) begin
         // A redirect seen during a stall is not latched; decode keeps it asserted.
         sel = NPC_HOLD;
         npc = pc;
      end else if (redirect_valid) begin
         sel = NPC_REDIR;
         npc = redirect_pc;
      end
   end

endmodule

// File: rtl/im_fetch.sv
// Instruction fetch: owns the PC, drives the I-memory, fills the IF/ID register.
// Latency: im_pc is the PC register directly; fetched word reaches IF/ID in 1 cycle.
// Backpressure: stall freezes PC and IF/ID; exc/eret flush IF/ID to a bubble even when stalled.
// Ports: clk/reset_n; stall, redirect_valid/redirect_pc, exc_req, eret_req/epc from
//        decode and CP0; im_pc/im_instr/im_adel to memory; d_pc/d_instr/d_valid/d_adel/d_bd to decode.
module im_fetch
   import cpu_defs::*;
#(
   parameter logic [31:0] RESET_PC   = CPU_RESET_PC,
   parameter logic [31:0] EXC_VECTOR = CPU_EXC_VECTOR,
   parameter logic [31:0] NOP_WORD   = CPU_NOP_WORD
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        exc_req,
   input  logic        eret_req,
   input  logic [31:0] epc,
   output logic [31:0] im_pc,
   input  logic [31:0] im_instr,
   input  logic        im_adel,
   output logic [31:0] d_pc,
   output logic [31:0] d_instr,
   output logic        d_valid,
   output logic        d_adel,
   output logic        d_bd
);

   localparam ifid_t IFID_BUBBLE = '{pc: 32'h0, instr: NOP_WORD, valid: 1'b0, adel: 1'b0, bd: 1'b0};

   logic [31:0] pc;
   logic [31:0] npc;
   npc_sel_t    sel;
   ifid_t       ifid;

   fetch_npc #(
      .EXC_VECTOR(EXC_VECTOR)
   ) u_npc (
      .pc             (pc),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .exc_req        (exc_req),
      .eret_req       (eret_req),
      .epc            (epc),
      .npc            (npc),
      .sel            (sel)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc   <= RESET_PC;
         ifid <= IFID_BUBBLE;
      end else begin
         pc <= npc;
         case (sel)
            NPC_EXC, NPC_ERET: ifid <= IFID_BUBBLE;
            NPC_HOLD:          ifid <= ifid;
            default: begin
               // The word fetched this cycle is the delay slot when a redirect is applied.
               // A faulted fetch still enters decode so CP0 can take AdEL on it.
               ifid.pc    <= pc;
               ifid.valid <= 1'b1;
               ifid.bd    <= (sel == NPC_REDIR);
               ifid.adel  <= im_adel;
               ifid.instr <= im_adel ? NOP_WORD : im_instr;
            end
         endcase
      end
   end

   assign im_pc   = pc;
   assign d_pc    = ifid.pc;
   assign d_instr = ifid.instr;
   assign d_valid = ifid.valid;
   assign d_adel  = ifid.adel;
   assign d_bd    = ifid.bd;

endmodule

// File: tb/tb_im_fetch.sv
// Directed bench for im_fetch: vector table plus async-reset sequence.
// Latency: n/a.
// Backpressure: n/a.
module tb_im_fetch;
   import cpu_defs::*;

   logic        clk;
   logic        reset_n;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        exc_req;
   logic        eret_req;
   logic [31:0] epc;
   logic [31:0] im_pc;
   logic [31:0] im_instr;
   logic        im_adel;
   logic [31:0] d_pc;
   logic [31:0] d_instr;
   logic        d_valid;
   logic        d_adel;
   logic        d_bd;

   int errors = 0;
   int checks = 0;

   im_fetch dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .exc_req        (exc_req),
      .eret_req       (eret_req),
      .epc            (epc),
      .im_pc          (im_pc),
      .im_instr       (im_instr),
      .im_adel        (im_adel),
      .d_pc           (d_pc),
      .d_instr        (d_instr),
      .d_valid        (d_valid),
      .d_adel         (d_adel),
      .d_bd           (d_bd)
   );

   // Memory model: recognisable word per address, AdEL outside the window.
   assign im_instr = {16'hA5C3, im_pc[15:0]};
   assign im_adel  = !im_addr_ok(im_pc);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        stall;
      logic        rv;
      logic [31:0] rpc;
      logic        exc;
      logic        eret;
      logic [31:0] epc;
      logic [31:0] e_im;
      logic [31:0] e_dpc;
      logic [31:0] e_dinstr;
      logic        e_v;
      logic        e_adel;
      logic        e_bd;
   } vec_t;

   vec_t vecs[21];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [31:0] e_im, input logic [31:0] e_dpc,
                          input logic [31:0] e_di, input logic e_v, input logic e_ad, input logic e_bd);
      chk({tag, ".im_pc"},   im_pc,   e_im);
      chk({tag, ".d_pc"},    d_pc,    e_dpc);
      chk({tag, ".d_instr"}, d_instr, e_di);
      chk({tag, ".d_valid"}, {31'b0, d_valid}, {31'b0, e_v});
      chk({tag, ".d_adel"},  {31'b0, d_adel},  {31'b0, e_ad});
      chk({tag, ".d_bd"},    {31'b0, d_bd},    {31'b0, e_bd});
   endtask

   task automatic idle_inputs();
      stall = 0; redirect_valid = 0; redirect_pc = 0;
      exc_req = 0; eret_req = 0; epc = 0;
   endtask

   initial begin
      //              stall rv rpc           exc eret epc           im_pc         d_pc          d_instr       v  adel bd
      vecs[0]  = '{0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3004, 32'h0000_3000, 32'hA5C3_3000, 1, 0, 0};
      vecs[1]  = '{0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3008, 32'h0000_3004, 32'hA5C3_3004, 1, 0, 0};
      vecs[2]  = '{0, 1, 32'h0000_3100, 0, 0, 32'h0,         32'h0000_3100, 32'h0000_3008, 32'hA5C3_3008, 1, 0, 1};
      vecs[3]  = '{0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3104, 32'h0000_3100, 32'hA5C3_3100, 1, 0, 0};
      vecs[4]  = '{0, 1, 32'h0000_3010, 0, 0, 32'h0,         32'h0000_3010, 32'h0000_3104, 32'hA5C3_3104, 1, 0, 1};
      // stall with a pending redirect: nothing moves
      vecs[5]  = '{1, 1, 32'h0000_3200, 0, 0, 32'h0,         32'h0000_3010, 32'h0000_3104, 32'hA5C3_3104, 1, 0, 1};
      vecs[6]  = '{1, 1, 32'h0000_3200, 0, 0, 32'h0,         32'h0000_3010, 32'h0000_3104, 32'hA5C3_3104, 1, 0, 1};
      vecs[7]  = '{0, 1, 32'h0000_3200, 0, 0, 32'h0,         32'h0000_3200, 32'h0000_3010, 32'hA5C3_3010, 1, 0, 1};
      vecs[8]  = '{0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3204, 32'h0000_3200, 32'hA5C3_3200, 1, 0, 0};
      vecs[9]  = '{0, 1, 32'h0000_3020, 0, 0, 32'h0,         32'h0000_3020, 32'h0000_3204, 32'hA5C3_3204, 1, 0, 1};
      // exception overrides stall
      vecs[10] = '{1, 0, 32'h0,         1, 0, 32'h0,         32'h0000_4180, 32'h0,         32'h0,         0, 0, 0};
      vecs[11] = '{0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_4184, 32'h0000_4180, 32'hA5C3_4180, 1, 0, 0};
      vecs[12] = '{0, 0, 32'h0,         0, 1, 32'h0000_3024, 32'h0000_3024, 32'h0,         32'h0,         0, 0, 0};
      // exc beats eret
      vecs[13] = '{0, 0, 32'h0,         1, 1, 32'h0000_3024, 32'h0000_4180, 32'h0,         32'h0,         0, 0, 0};
      // misaligned redirect target
      vecs[14] = '{0, 1, 32'h0000_3002, 0, 0, 32'h0,         32'h0000_3002, 32'h0000_4180, 32'hA5C3_4180, 1, 0, 1};
      vecs[15] = '{0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3006, 32'h0000_3002, 32'h0,         1, 1, 0};
      vecs[16] = '{0, 0, 32'h0,         1, 0, 32'h0,         32'h0000_4180, 32'h0,         32'h0,         0, 0, 0};
      // PC+4 wraps past 2^32; out-of-window fetches flag AdEL
      vecs[17] = '{0, 0, 32'h0,         0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,         32'h0,         0, 0, 0};
      vecs[18] = '{0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_0000, 32'hFFFF_FFFC, 32'h0,         1, 1, 0};
      vecs[19] = '{0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_0004, 32'h0000_0000, 32'h0,         1, 1, 0};
      // eret overrides stall
      vecs[20] = '{1, 0, 32'h0,         0, 1, 32'h0000_3000, 32'h0000_3000, 32'h0,         32'h0,         0, 0, 0};

      idle_inputs();
      reset_n = 1'b0;
      #12;
      chk_all("reset", 32'h0000_3000, 32'h0, 32'h0, 0, 0, 0);
      reset_n = 1'b1;   // released mid-cycle, first active edge at t=15
      #2;

      for (int i = 0; i < 21; i++) begin
         stall = vecs[i].stall; redirect_valid = vecs[i].rv; redirect_pc = vecs[i].rpc;
         exc_req = vecs[i].exc; eret_req = vecs[i].eret; epc = vecs[i].epc;
         @(posedge clk);
         #1;
         chk_all($sformatf("v%0d", i), vecs[i].e_im, vecs[i].e_dpc, vecs[i].e_dinstr,
                 vecs[i].e_v, vecs[i].e_adel, vecs[i].e_bd);
      end

      // Advance to a populated IF/ID, then pull reset mid-cycle during a redirect.
      idle_inputs();
      @(posedge clk); #1;
      chk_all("pre_rst", 32'h0000_3004, 32'h0000_3000, 32'hA5C3_3000, 1, 0, 0);
      redirect_valid = 1; redirect_pc = 32'h0000_3300;
      #3;
      reset_n = 1'b0;
      #1;
      chk_all("async_rst", 32'h0000_3000, 32'h0, 32'h0, 0, 0, 0);
      @(posedge clk); #1;
      chk_all("rst_hold", 32'h0000_3000, 32'h0, 32'h0, 0, 0, 0);
      idle_inputs();
      #3;
      reset_n = 1'b1;
      @(posedge clk); #1;
      chk_all("restart0", 32'h0000_3004, 32'h0000_3000, 32'hA5C3_3000, 1, 0, 0);
      @(posedge clk); #1;
      chk_all("restart1", 32'h0000_3008, 32'h0000_3004, 32'hA5C3_3004, 1, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/im_fetch.md
Name: im_fetch

Overview:
- Instruction-fetch initiator for the instruction memory port. Owns the fetch PC and drives it to the memory.
- Takes back the instruction word and the memory's AdEL flag.
- Registers the fetched instruction into the IF/ID pipeline register.
- Applies branch/jump redirects with one architectural delay slot, exception entry, and ERET return, with stall and flush control for the MIPS pipeline.

Parameters:
- RESET_PC, 32'h0000_3000, fetch address after reset.
- EXC_VECTOR, 32'h0000_4180, exception handler entry address.
- NOP_WORD, 32'h0000_0000, instruction word inserted for bubbles and faulted fetches.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- stall  in  1  freeze the PC and the IF/ID register (load-use/busy hazard from decode).
- redirect_valid  in  1  decode has a taken branch/jump; the instruction currently in fetch is its delay slot.
- redirect_pc  in  32  branch/jump target.
- exc_req  in  1  CP0 exception taken; flush and go to EXC_VECTOR.
- eret_req  in  1  ERET committing; flush and go to epc.
- epc  in  32  return address from CP0.
- im_pc  out  32  fetch address to the instruction memory (equals the PC register).
- im_instr  in  32  instruction word returned combinationally for im_pc.
- im_adel  in  1  memory flags im_pc as misaligned or outside 0x3000..0x6ffc.
- d_pc  out  32  PC of the instruction in the IF/ID register.
- d_instr  out  32  instruction in the IF/ID register.
- d_valid  out  1  IF/ID holds a real instruction, not a bubble.
- d_adel  out  1  fetch address error travels with this instruction.
- d_bd  out  1  this instruction is a branch delay slot.

Behaviour:
- Reset (async, reset_n=0):
  - PC=RESET_PC.
  - d_pc=0, d_instr=NOP_WORD, d_valid=0, d_adel=0, d_bd=0.
  - Release takes effect on the first rising edge after reset_n=1. The first fetch presents RESET_PC to memory in that cycle.
- im_pc = PC combinationally. No added latency: the instruction at im_pc is captured into IF/ID at the same edge, so fetch-to-decode latency is 1 cycle.
- next-PC priority, highest first:
  1. exc_req -> EXC_VECTOR
  2. eret_req -> epc
  3. stall -> hold PC
  4. redirect_valid -> redirect_pc
  5. otherwise PC+4, 32-bit, wrapping modulo 2^32 with no saturation.
- IF/ID update, same priority order:
  - exc_req or eret_req: load bubble (d_valid=0, d_instr=NOP_WORD, d_adel=0, d_bd=0, d_pc=0). This overrides stall.
  - stall: hold all d_* outputs.
  - otherwise: d_pc=PC, d_valid=1, d_bd=redirect_valid.
    - If im_adel=1: d_instr=NOP_WORD, d_adel=1.
    - If im_adel=0: d_instr=im_instr, d_adel=0.
- Delay slot: on a redirect, the instruction fetched in that cycle (PC, not the target) always enters decode with d_bd=1. The target is fetched the following cycle.
- stall with redirect_valid in the same cycle: the redirect is not latched. Decode holds redirect_valid/redirect_pc asserted until the stall drops, and the block applies the redirect on that cycle.
- exc_req with eret_req together: exc_req wins.
- A faulted fetch still advances PC+4. CP0 flushes via exc_req when the faulted instruction reaches it.
- Reset asserted mid-stall or mid-redirect: all state returns to reset values immediately, and pending redirects are lost.
- The state machine is implicit; the state is the PC register plus the IF/ID register. There are no hidden pending registers.

Decomposition:
- Shared package (cpu_defs): RESET_PC, EXC_VECTOR, NOP_WORD, IM address bounds 0x3000/0x6ffc. The memory and this block use the same constants.
- One natural sub-module: fetch_npc, a purely combinational next-PC priority mux (exc/eret/stall/redirect/seq).
- The PC register and the IF/ID register stay in im_fetch.

Test Plan:
- Reset release, no stalls, 4 cycles:
  - im_pc = 3000, 3004, 3008, 300c.
  - d_pc lags by one cycle, d_valid=1 from the 2nd cycle, d_bd=0.
- redirect_valid=1 with redirect_pc=0x3100 while PC=0x3008:
  - Next cycle: d_pc=3008, d_bd=1, im_pc=3100.
  - Following cycle: d_pc=3100, d_bd=0.
- stall=1 for 2 cycles at PC=0x3010:
  - im_pc holds at 3010 and d_* is unchanged.
  - Combined with redirect_valid held through the stall, the redirect is applied only on the first unstalled edge.
- exc_req=1 together with stall=1 at PC=0x3020:
  - Next cycle: im_pc=0x4180, d_valid=0, d_instr=0.
  - eret_req with epc=0x3024 -> im_pc=0x3024 and a bubble in IF/ID.
- redirect_pc=0x3002 (memory asserts im_adel):
  - d_pc=3002, d_instr=0, d_adel=1, d_valid=1.
  - Next im_pc=0x3006.
  - A following exc_req sends im_pc to 0x4180.
- reset_n pulsed low asynchronously mid-cycle during a redirect:
  - Outputs go to reset values before the next edge.
  - After release, fetch restarts at 0x3000.
